// File: rtl/axis_response_header_builder_pkg.sv
// Shared definitions for the response header builder and the inbound parser:
// magic word, header geometry, header word indices and FSM state encoding.
// Build option HDR_CHECKSUM_EN adds the TRAIL state for the XOR trailer word.
package axis_response_header_builder_pkg;

  localparam logic [15:0] MAGIC_WORD_DEFAULT = 16'hC0DE;
  localparam int unsigned HDR_WORDS          = 6;

  localparam logic [2:0] HDR_MAGIC  = 3'd0;
  localparam logic [2:0] HDR_INSTR  = 3'd1;
  localparam logic [2:0] HDR_BEND   = 3'd2;
  localparam logic [2:0] HDR_ASTART = 3'd3;
  localparam logic [2:0] HDR_ACOUNT = 3'd4;
  localparam logic [2:0] HDR_LEN    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
`ifdef HDR_CHECKSUM_EN
    , ST_TRAIL
`endif
  } state_e;

endpackage

// File: rtl/axis_response_header_builder_hdr_mux.sv
// Combinational selector producing one response header word from the header
// index and the latched control fields. Upper bits are zero when
// DATA_WIDTH exceeds 16.
module axis_hdr_word_mux
  import axis_response_header_builder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter logic [15:0] MAGIC_WORD = MAGIC_WORD_DEFAULT
) (
  input  logic [2:0]            hdr_idx_i,
  input  logic [7:0]            instr_i,
  input  logic [4:0]            bram_start_i,
  input  logic [4:0]            bram_end_i,
  input  logic [15:0]           addr_start_i,
  input  logic [15:0]           addr_count_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  // Header word select.
  always_comb begin
    word_o = '0;
    case (hdr_idx_i)
      HDR_MAGIC:  word_o = DATA_WIDTH'(MAGIC_WORD);
      HDR_INSTR:  word_o = DATA_WIDTH'({instr_i, 3'b000, bram_start_i});
      HDR_BEND:   word_o = DATA_WIDTH'({11'd0, bram_end_i});
      HDR_ASTART: word_o = DATA_WIDTH'(addr_start_i);
      HDR_ACOUNT: word_o = DATA_WIDTH'(addr_count_i);
      HDR_LEN:    word_o = DATA_WIDTH'(len_i);
      default:    word_o = '0;
    endcase
  end

endmodule

// File: rtl/axis_response_header_builder.sv
// Response packet builder: on start, latches the operation's control fields,
// emits a 6-word header, then passes exactly payload_len upstream words
// through to the DMA with TLAST on the final word.
// Build option HDR_CHECKSUM_EN appends an XOR-of-all-words trailer that
// carries TLAST instead.
module axis_response_header_builder
  import axis_response_header_builder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [15:0] MAGIC_WORD = MAGIC_WORD_DEFAULT,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [7:0]            instruction_code,
  input  logic [4:0]            bram_start,
  input  logic [4:0]            bram_end,
  input  logic [15:0]           addr_start,
  input  logic [15:0]           addr_count,
  input  logic [LEN_WIDTH-1:0]  payload_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len_mismatch
);

  state_e                state_q, state_d;
  logic [2:0]            hdr_idx_q, hdr_idx_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [7:0]            instr_q;
  logic [4:0]            bram_start_q, bram_end_q;
  logic [15:0]           addr_start_q, addr_count_q;
  logic [LEN_WIDTH-1:0]  len_q;

  logic [DATA_WIDTH-1:0] hdr_word;
  logic                  accept_start;
  logic                  last_hdr;
  logic                  last_pl;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign last_hdr     = (hdr_idx_q == HDR_LEN);
  assign last_pl      = (cnt_q == (len_q - LEN_WIDTH'(1)));

  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign err_len_mismatch = err_q;

  axis_hdr_word_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MAGIC_WORD (MAGIC_WORD)
  ) u_hdr_mux (
    .hdr_idx_i    (hdr_idx_q),
    .instr_i      (instr_q),
    .bram_start_i (bram_start_q),
    .bram_end_i   (bram_end_q),
    .addr_start_i (addr_start_q),
    .addr_count_i (addr_count_q),
    .len_i        (len_q),
    .word_o       (hdr_word)
  );

`ifdef HDR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  // Running XOR of every word that handshakes on the output stream.
  always_comb begin
    csum_d = csum_q;
    if (accept_start) begin
      csum_d = '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      csum_d = csum_q ^ m_axis_tdata;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Control-field capture; only an accepted start may overwrite the fields.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      instr_q      <= '0;
      bram_start_q <= '0;
      bram_end_q   <= '0;
      addr_start_q <= '0;
      addr_count_q <= '0;
      len_q        <= '0;
    end else if (accept_start) begin
      instr_q      <= instruction_code;
      bram_start_q <= bram_start;
      bram_end_q   <= bram_end;
      addr_start_q <= addr_start;
      addr_count_q <= addr_count;
      len_q        <= payload_len;
    end
  end

  // FSM state, header index, payload counter and status flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic and stream outputs; PAYLOAD is a combinational bypass.
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
        end
      end

      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word;
`ifndef HDR_CHECKSUM_EN
        m_axis_tlast  = last_hdr && (len_q == '0);
`endif
        if (m_axis_tready) begin
          if (!last_hdr) begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end else if (len_q != '0) begin
            state_d = ST_PAYLOAD;
          end else begin
`ifdef HDR_CHECKSUM_EN
            state_d = ST_TRAIL;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

      ST_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
`ifndef HDR_CHECKSUM_EN
        m_axis_tlast  = last_pl;
`endif
        if (s_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (s_axis_tlast != last_pl) begin
            err_d = 1'b1;
          end
          if (last_pl) begin
`ifdef HDR_CHECKSUM_EN
            state_d = ST_TRAIL;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef HDR_CHECKSUM_EN
      ST_TRAIL: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = csum_q;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_response_header_builder.sv
// Randomized bench for axis_response_header_builder. Expected packets are
// built as word lists from the header layout plus the upstream payload
// (plus XOR trailer when HDR_CHECKSUM_EN is defined).
module tb_axis_response_header_builder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  instruction_code = '0;
  logic [4:0]  bram_start = '0;
  logic [4:0]  bram_end = '0;
  logic [15:0] addr_start = '0;
  logic [15:0] addr_count = '0;
  logic [15:0] payload_len = '0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic        err_len_mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] src[$];
  logic [15:0] exp_q[$];

  always #5 aclk = ~aclk;

  axis_response_header_builder #(
    .DATA_WIDTH (16),
    .MAGIC_WORD (16'hC0DE),
    .LEN_WIDTH  (16)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .instruction_code (instruction_code),
    .bram_start       (bram_start),
    .bram_end         (bram_end),
    .addr_start       (addr_start),
    .addr_count       (addr_count),
    .payload_len      (payload_len),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .busy             (busy),
    .done             (done),
    .err_len_mismatch (err_len_mismatch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Drives one packet request and checks every cycle until its done pulse.
  // src must hold len payload words. rdy_mode: 100 = always ready,
  // 0 = repeating 1-0-0-1 pattern, otherwise percent chance of ready.
  task automatic run_packet(input logic [7:0] ic, input logic [4:0] bs, input logic [4:0] be,
                            input logic [15:0] as_w, input logic [15:0] ac, input int len,
                            input int tl_at, input int rdy_mode, input int vld_pct,
                            input bit busy_start);
    int total, out_idx, src_idx, cyc;
    bit exp_err, in_hdr, in_pl, hs;
    logic [15:0] x;

    exp_q.delete();
    exp_q.push_back(16'hC0DE);
    exp_q.push_back({ic, 3'b000, bs});
    exp_q.push_back({11'd0, be});
    exp_q.push_back(as_w);
    exp_q.push_back(ac);
    exp_q.push_back(16'(len));
    for (int i = 0; i < len; i++) exp_q.push_back(src[i]);
`ifdef HDR_CHECKSUM_EN
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`else
    x = '0;
`endif
    total = exp_q.size();

    @(posedge aclk) #1;
    check("idle_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    instruction_code = ic;
    bram_start = bs;
    bram_end = be;
    addr_start = as_w;
    addr_count = ac;
    payload_len = 16'(len);
    start = 1'b1;
    @(posedge aclk) #1;
    start = 1'b0;
    // Scramble the request inputs: the packet must use the latched copies.
    instruction_code = 8'($urandom);
    bram_start = 5'($urandom);
    bram_end = 5'($urandom);
    addr_start = 16'($urandom);
    addr_count = 16'($urandom);
    payload_len = 16'($urandom);

    out_idx = 0;
    src_idx = 0;
    exp_err = 1'b0;
    cyc = 0;
    while (out_idx < total && cyc < 4000) begin
      if (rdy_mode >= 100) m_axis_tready = 1'b1;
      else if (rdy_mode == 0) m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else m_axis_tready = ($urandom_range(99) < rdy_mode);
      s_axis_tvalid = (src_idx < len) && ($urandom_range(99) < vld_pct);
      if (s_axis_tvalid) begin
        s_axis_tdata = src[src_idx];
        s_axis_tlast = (src_idx + 1 == tl_at);
      end else begin
        s_axis_tdata = 16'($urandom);
        s_axis_tlast = 1'($urandom);
      end
      start = busy_start && (out_idx == 7);
      #4;
      in_hdr = (out_idx < 6);
      in_pl  = !in_hdr && (out_idx < 6 + len);
      check("busy", {31'd0, busy}, 1);
      check("done_early", {31'd0, done}, 0);
      check("err", {31'd0, err_len_mismatch}, {31'd0, exp_err});
      check("s_tready", {31'd0, s_axis_tready}, in_pl ? {31'd0, m_axis_tready} : 0);
      check("tvalid", {31'd0, m_axis_tvalid}, in_pl ? {31'd0, s_axis_tvalid} : 1);
      if (m_axis_tvalid) begin
        check("tdata", {16'd0, m_axis_tdata}, {16'd0, exp_q[out_idx]});
        check("tlast", {31'd0, m_axis_tlast}, (out_idx == total - 1) ? 1 : 0);
      end
      hs = m_axis_tvalid && m_axis_tready;
      if (hs && in_pl) begin
        if (s_axis_tlast != (src_idx == len - 1)) exp_err = 1'b1;
        src_idx++;
      end
      if (hs) out_idx++;
      @(posedge aclk) #1;
      cyc++;
    end
    check("complete", out_idx, total);

    start = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    #4;
    check("done_pulse", {31'd0, done}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    check("tvalid_after", {31'd0, m_axis_tvalid}, 0);
    check("err_final", {31'd0, err_len_mismatch}, (len > 0 && tl_at != len) ? 1 : 0);
    @(posedge aclk) #4;
    check("done_once", {31'd0, done}, 0);
    check("no_restart", {31'd0, busy}, 0);
  endtask

  initial begin
    int len, tl_at;

    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 0);
    check("rst_tdata", {16'd0, m_axis_tdata}, 0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err_len_mismatch}, 0);
    aresetn = 1'b1;

    // Header content with a known 3-word payload.
    src = '{16'h0001, 16'h0002, 16'h0004};
    run_packet(8'h12, 5'd2, 5'd5, 16'h0010, 16'h0004, 3, 3, 100, 100, 1'b0);

    // Zero-length payload.
    src.delete();
    run_packet(8'h34, 5'd1, 5'd1, 16'h0100, 16'h0000, 0, 0, 100, 100, 1'b0);

    // Backpressure pattern through header and payload.
    src = '{16'hAAAA, 16'h5555, 16'h1234, 16'h8001};
    run_packet(8'h12, 5'd2, 5'd5, 16'h0010, 16'h0004, 4, 4, 0, 100, 1'b0);

    // Early upstream TLAST, then a clean packet must clear the flag.
    src = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    run_packet(8'h56, 5'd3, 5'd7, 16'h0020, 16'h0008, 4, 2, 100, 100, 1'b0);
    src = '{16'h0f0f, 16'hf0f0};
    run_packet(8'h57, 5'd0, 5'd31, 16'hFFFF, 16'hFFFF, 2, 2, 100, 100, 1'b0);

    // Start while busy is ignored.
    src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_packet(8'h9A, 5'd4, 5'd9, 16'h0040, 16'h0005, 5, 5, 100, 100, 1'b1);

    // Reset during the header aborts the packet.
    @(posedge aclk) #1;
    m_axis_tready = 1'b0;
    instruction_code = 8'h77;
    payload_len = 16'd3;
    start = 1'b1;
    @(posedge aclk) #1;
    start = 1'b0;
    @(posedge aclk) #1;
    aresetn = 1'b0;
    @(posedge aclk) #1;
    check("abort_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_tlast", {31'd0, m_axis_tlast}, 0);
    check("abort_done", {31'd0, done}, 0);
    aresetn = 1'b1;
    src = '{16'hBEEF, 16'hCAFE, 16'hF00D};
    run_packet(8'h12, 5'd2, 5'd5, 16'h0010, 16'h0004, 3, 3, 100, 100, 1'b0);

    // Randomized packets.
    repeat (20) begin
      len = $urandom_range(0, 12);
      tl_at = ($urandom_range(3) == 0) ? $urandom_range(0, len + 1) : len;
      src.delete();
      for (int i = 0; i < len; i++) src.push_back(16'($urandom));
      run_packet(8'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                 len, tl_at, $urandom_range(30, 100), $urandom_range(30, 100),
                 (len >= 2) && ($urandom_range(1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_response_header_builder.md
Name: axis_response_header_builder

Overview:
- Transmit-side counterpart to the inbound header parser. It sits between the BRAM read path (payload AXI-Stream out of the custom top) and the DMA S2MM channel.
- On a start pulse it latches the control fields of the completed operation and emits a 6-word response header.
- It then forwards exactly `payload_len` payload words and asserts TLAST on the final word of the packet.
- The PS decodes the returned packet with the same field layout it uses for commands.

Parameters:
- DATA_WIDTH, 16, stream word width; header packing requires ≥16.
- MAGIC_WORD, 16'hC0DE, constant emitted as header word 0.
- LEN_WIDTH, 16, width of the payload length and word counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to build a packet; honoured only in IDLE.
- instruction_code  in  8  echoed into the header.
- bram_start  in  5  echoed into the header.
- bram_end  in  5  echoed into the header.
- addr_start  in  16  echoed into the header.
- addr_count  in  16  echoed into the header.
- payload_len  in  LEN_WIDTH  number of payload words to forward.
- s_axis_tdata  in  DATA_WIDTH  payload from the BRAM reader.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload ready.
- s_axis_tlast  in  1  upstream end marker; used only for the consistency check.
- m_axis_tdata  out  DATA_WIDTH  stream to the DMA.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last word of the packet.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- err_len_mismatch  out  1  sticky flag; cleared by an accepted start.

Behaviour:
- Reset (`aresetn` = 0 at posedge): state = IDLE; latched fields = 0; counters = 0. All outputs are 0: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `s_axis_tready`, `busy`, `done`, `err_len_mismatch`.
- Reset asserted mid-packet aborts the packet immediately. No TLAST is emitted.
- States: IDLE → HDR → PAYLOAD → IDLE. A TRAIL state exists only when the optional feature is compiled in.
- IDLE:
  - `start` = 1 latches all control inputs and `payload_len`, clears `hdr_idx` and the word counter, clears `err_len_mismatch`, and moves to HDR.
  - `m_axis_tvalid` rises on the next cycle (1-cycle start latency).
- HDR:
  - `m_axis_tvalid` = 1; `m_axis_tdata` = header word[`hdr_idx`]. Header layout:
    - W0 = MAGIC_WORD.
    - W1 = {instruction_code, 3'b0, bram_start}.
    - W2 = {11'b0, bram_end}.
    - W3 = addr_start.
    - W4 = addr_count.
    - W5 = payload_len.
  - Upper bits are zero-extended if DATA_WIDTH > 16.
  - `hdr_idx` advances only on handshake (`m_axis_tvalid` & `m_axis_tready`). Data is stable while stalled.
  - `s_axis_tready` = 0 throughout HDR.
  - After the W5 handshake: go to PAYLOAD if `payload_len` ≠ 0; otherwise W5 carries TLAST and the block returns to IDLE.
- PAYLOAD: zero-latency combinational pass-through.
  - `m_axis_tdata` = `s_axis_tdata`; `m_axis_tvalid` = `s_axis_tvalid`; `s_axis_tready` = `m_axis_tready`.
  - The counter increments on each handshake.
  - `m_axis_tlast` = 1 when counter == `payload_len` − 1, independent of `s_axis_tlast`.
  - After the last handshake, return to IDLE.
- `done` pulses in the cycle after the final handshake (W5 when `payload_len` = 0, last payload word, or trailer). `busy` is low in that same cycle.
- Mismatch check: set `err_len_mismatch` when either occurs:
  - `s_axis_tlast` = 1 on a handshake that is not the last payload word; or
  - the last payload word handshakes with `s_axis_tlast` = 0.
  - The packet still completes with exactly `payload_len` words. Upstream beats are never dropped or extended.
- `start` while busy: ignored; latched fields are not disturbed.
- Counter width is LEN_WIDTH. `payload_len` = 2^LEN_WIDTH − 1 is legal; there is no wrap within a packet.

Optional Feature:
- Macro: `HDR_CHECKSUM_EN`.
- Defined:
  - A running XOR of every emitted word (W0..W5 plus payload) is accumulated on each handshake.
  - After the final payload word (or after W5 if `payload_len` = 0), TRAIL emits one extra word equal to the XOR.
  - TLAST moves onto the trailer, and `done` follows the trailer handshake.
- Undefined: no accumulator, no TRAIL state, no trailer; the packet length is 6 + `payload_len`.

Decomposition:
- Shared package: MAGIC_WORD default, HDR_WORDS = 6, header word index constants (HDR_MAGIC..HDR_LEN), and the state encoding. The inbound parser reuses the same package.
- One natural sub-module: `axis_hdr_word_mux`, a combinational selector from `hdr_idx` plus latched fields to header word.
- The FSM, counter and checksum stay in the top.

Test Plan:
- Header content: start with instr=0x12, bram 2..5, addr_start=0x0010, addr_count=4, len=3, tready=1, upstream supplies 3 words with tlast on the 3rd → output 0xC0DE, 0x1202, 0x0005, 0x0010, 0x0004, 0x0003, then the 3 payload words; TLAST on the 9th word only; done pulses once; err=0.
- Zero payload: len=0 → exactly 6 words, TLAST on W5 (0x0000), s_axis_tready never high.
- Backpressure: tready toggles 1-0-0-1 through the header and payload → data held stable while stalled, no beats lost or duplicated, word order identical to the unstalled run.
- Mismatch: len=4, upstream tlast on the 2nd word → err_len_mismatch=1 from that cycle; 4 payload words still forwarded; TLAST on the 4th; next start clears err.
- Start while busy plus mid-packet reset: a second start during PAYLOAD is ignored; aresetn=0 during HDR → next cycle tvalid=0, busy=0, tlast=0; a subsequent start produces a correct full packet.
- With `HDR_CHECKSUM_EN`: header as in the first scenario plus payload 0x0001, 0x0002, 0x0004 → a 10th word equal to the XOR of all 9 prior words, carrying TLAST.
